colour_sequencer: RTL and testbench

- Controller that drives the RGB colour converter's `color[2:0]` and `enable` inputs.
- Auto mode: steps through the eight colour codes, holding each for a programmable number of clock cycles.
- Manual override: a requester may push a one-off colour over a valid/ready handshake; after the hold, auto sequencing resumes where it left off.
- Sits between the LED/control logic and the converter in the display path.

---
 rtl/colour_sequencer_pkg.sv | 62 ++++++
 rtl/colour_sequencer_dwell_timer.sv | 39 +++
 rtl/colour_sequencer.sv | 161 ++++++++++++++++
 tb/tb_colour_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/colour_sequencer_pkg.sv
// Shared types and constants for the colour sequencer and its dwell timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package colour_sequencer_pkg;

    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [2:0] C_BLACK   = 3'd0;
    localparam logic [2:0] C_BLUE    = 3'd1;
    localparam logic [2:0] C_GREEN   = 3'd2;
    localparam logic [2:0] C_CYAN    = 3'd3;
    localparam logic [2:0] C_RED     = 3'd4;
    localparam logic [2:0] C_MAGENTA = 3'd5;
    localparam logic [2:0] C_YELLOW  = 3'd6;
    localparam logic [2:0] C_WHITE   = 3'd7;

    // Result of one auto-sequence advance.
    typedef struct packed {
        logic [2:0] color;
        dir_t       dir;
        logic       wrap;
    } step_t;

    // Next colour in the auto sequence.
    // mode 0: count-up with wrap 7->0 (wrap flagged on that step).
    // mode 1: ping-pong 0..7,6..0,1..; each endpoint shown once, wrap flagged on 1->0.
    function automatic step_t next_step(input logic [2:0] color, input dir_t dir, input logic mode);
        step_t s;
        s.color = color + 3'd1;
        s.dir   = dir;
        s.wrap  = 1'b0;
        if (!mode) begin
            s.wrap = (color == C_WHITE);
        end else if (dir == DIR_UP) begin
            if (color == C_WHITE) begin
                s.color = C_YELLOW;
                s.dir   = DIR_DOWN;
            end
        end else begin
            if (color == C_BLACK) begin
                s.color = C_BLUE;
                s.dir   = DIR_UP;
            end else begin
                s.color = color - 3'd1;
                s.wrap  = (color == C_BLUE);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/colour_sequencer_dwell_timer.sv
// Loadable dwell down-counter; expire_o flags the last cycle of a dwell (count==1).
// Latency: load takes effect on the next edge; expire_o is a decode of the register.
// Backpressure: none; count floors at 1 and holds there while enabled.
// Ports: clk/rst_n clock and async reset, load_i reload with eff_i, en_i decrement enable,
//        expire_o asserted while the count is 1.
module colour_sequencer_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] eff_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = eff_i;
        end else if (en_i && (count_q > W'(1))) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/colour_sequencer.sv
// Drives the RGB converter colour/enable: auto sequencing with per-colour dwell plus one-off manual override.
// Latency: every output is registered; effects appear on the edge after the triggering input.
// Backpressure: req_ready low while a manual colour is held and for one cycle after stop; requests not queued.
// Ports: start/stop level controls, mode (0 wrap, 1 ping-pong), dwell hold length, req_valid/req_color/req_ready
//        override handshake, color/enable to converter, busy (not idle), wrap (one pulse per sequence cycle).
module colour_sequencer
    import colour_sequencer_pkg::*;
#(
    parameter int DWELL_W   = DWELL_W_DEF,
    parameter int DWELL_MIN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               req_valid,
    input  logic [2:0]         req_color,
    output logic               req_ready,
    output logic [2:0]         color,
    output logic               enable,
    output logic               busy,
    output logic               wrap
);

    state_t     state_q, state_d;
    logic [2:0] color_q, color_d;
    logic [2:0] saved_q, saved_d;
    dir_t       dir_q, dir_d;
    logic       enable_q, enable_d;
    logic       wrap_q, wrap_d;
    logic       req_ready_q, req_ready_d;
    logic       ret_run_q, ret_run_d;   // 1: HOLD returns to RUN, 0: to IDLE

    logic               load;
    logic               expire;
    logic               accept;
    logic [DWELL_W-1:0] eff;
    step_t              step;

    assign eff    = (dwell == '0) ? DWELL_W'(DWELL_MIN) : dwell;
    assign step   = next_step(color_q, dir_q, mode);
    // req_ready_q is only ever high outside HOLD; the state term keeps that explicit.
    assign accept = req_valid && req_ready_q && (state_q != S_HOLD);

    colour_sequencer_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .en_i     (state_q != S_IDLE),
        .eff_i    (eff),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        color_d   = color_q;
        saved_d   = saved_q;
        dir_d     = dir_q;
        enable_d  = enable_q;
        wrap_d    = 1'b0;
        ret_run_d = ret_run_q;
        load      = 1'b0;

        if (stop) begin
            // Abandon everything; colour is left showing but the converter is disabled.
            state_d  = S_IDLE;
            enable_d = 1'b0;
            saved_d  = C_BLACK;
        end else if (accept) begin
            // If the dwell expires on the accept edge, the advance still happens
            // so the resumed sequence does not repeat the colour it just finished.
            if ((state_q == S_RUN) && expire) begin
                saved_d = step.color;
                dir_d   = step.dir;
                wrap_d  = step.wrap;
            end else begin
                saved_d = color_q;
            end
            color_d   = req_color;
            enable_d  = 1'b1;
            ret_run_d = (state_q == S_RUN);
            load      = 1'b1;
            state_d   = S_HOLD;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    enable_d = 1'b0;
                    if (start) begin
                        state_d  = S_RUN;
                        color_d  = C_BLACK;
                        dir_d    = DIR_UP;
                        enable_d = 1'b1;
                        load     = 1'b1;
                    end
                end
                S_RUN: begin
                    enable_d = 1'b1;
                    if (expire) begin
                        color_d = step.color;
                        dir_d   = step.dir;
                        wrap_d  = step.wrap;
                        load    = 1'b1;
                    end
                end
                S_HOLD: begin
                    enable_d = 1'b1;
                    if (expire) begin
                        if (ret_run_q) begin
                            state_d = S_RUN;
                            color_d = saved_q;
                            load    = 1'b1;
                        end else begin
                            // Back to idle: the requested colour stays on the bus.
                            state_d  = S_IDLE;
                            enable_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    enable_d = 1'b0;
                end
            endcase
        end

        req_ready_d = !stop && (state_d != S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            color_q     <= C_BLACK;
            saved_q     <= C_BLACK;
            dir_q       <= DIR_UP;
            enable_q    <= 1'b0;
            wrap_q      <= 1'b0;
            req_ready_q <= 1'b0;
            ret_run_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            saved_q     <= saved_d;
            dir_q       <= dir_d;
            enable_q    <= enable_d;
            wrap_q      <= wrap_d;
            req_ready_q <= req_ready_d;
            ret_run_q   <= ret_run_d;
        end
    end

    assign req_ready = req_ready_q;
    assign color     = color_q;
    assign enable    = enable_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_colour_sequencer.sv
// Directed bench for colour_sequencer: reset, wrap and ping-pong sequencing, manual override, stop.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: exercised via req_valid held against req_ready low.
module tb_colour_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] dwell;
    logic        req_valid;
    logic [2:0]  req_color;
    logic        req_ready;
    logic [2:0]  color;
    logic        enable;
    logic        busy;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    colour_sequencer #(
        .DWELL_W   (16),
        .DWELL_MIN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .req_valid (req_valid),
        .req_color (req_color),
        .req_ready (req_ready),
        .color     (color),
        .enable    (enable),
        .busy      (busy),
        .wrap      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m;
        int exp_c;
        start = 0; stop = 0; mode = 0; dwell = 16'd0;
        req_valid = 0; req_color = 3'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_color", int'(color), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_ready", int'(req_ready), 0);
        tick(); tick();
        rst_n = 1'b1;
        chk("ready_pre_edge", int'(req_ready), 0);
        tick();
        chk("ready_after_rel", int'(req_ready), 1);

        // Count-up wrap, 3 cycles per colour.
        dwell = 16'd3; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("m0_enable", int'(enable), 1);
        chk("m0_busy", int'(busy), 1);
        chk("m0_color0", int'(color), 0);
        for (int i = 1; i <= 24; i++) begin
            tick();
            chk("m0_color", int'(color), (i / 3) % 8);
            chk("m0_wrap", int'(wrap), (i == 24) ? 1 : 0);
        end
        tick();
        chk("m0_wrap_clear", int'(wrap), 0);
        chk("m0_color_after", int'(color), 0);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_enable", int'(enable), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_ready", int'(req_ready), 0);
        tick();
        chk("stop_ready_back", int'(req_ready), 1);

        // Ping-pong with dwell floored to one cycle.
        dwell = 16'd0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pp_color0", int'(color), 0);
        for (int i = 1; i <= 19; i++) begin
            tick();
            m = i % 14;
            exp_c = (m <= 7) ? m : 14 - m;
            chk("pp_color", int'(color), exp_c);
            chk("pp_wrap", int'(wrap), (i == 14) ? 1 : 0);
        end

        // Asynchronous reset mid-run at colour 5.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_color", int'(color), 0);
        chk("arst_enable", int'(enable), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(req_ready), 0);
        tick();
        rst_n = 1'b1;
        chk("arst_ready_hold", int'(req_ready), 0);
        tick();
        chk("arst_ready_rel", int'(req_ready), 1);

        // Override from RUN at colour 2.
        mode = 1'b0; dwell = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("ov_pre_color", int'(color), 2);
        req_valid = 1'b1; req_color = 3'd6;
        tick();
        req_valid = 1'b0;
        chk("ov_color", int'(color), 6);
        chk("ov_ready", int'(req_ready), 0);
        chk("ov_enable", int'(enable), 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("ov_seq_color", int'(color), (i < 4) ? 6 : ((i < 8) ? 2 : 3));
            chk("ov_seq_ready", int'(req_ready), (i >= 4) ? 1 : 0);
        end

        // Request beats start in IDLE.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("idle_ready", int'(req_ready), 1);
        chk("idle_busy", int'(busy), 0);
        req_valid = 1'b1; req_color = 3'd5; start = 1'b1;
        tick();
        req_valid = 1'b0; start = 1'b0;
        chk("iq_color", int'(color), 5);
        chk("iq_busy", int'(busy), 1);
        chk("iq_enable", int'(enable), 1);
        chk("iq_ready", int'(req_ready), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("iq_hold_color", int'(color), 5);
            chk("iq_hold_enable", int'(enable), 1);
        end
        tick();
        chk("iq_end_busy", int'(busy), 0);
        chk("iq_end_enable", int'(enable), 0);
        chk("iq_end_color", int'(color), 5);
        chk("iq_end_ready", int'(req_ready), 1);

        // stop together with a request in RUN: no transfer.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("sr_pre_color", int'(color), 1);
        stop = 1'b1; req_valid = 1'b1; req_color = 3'd3;
        tick();
        stop = 1'b0;
        chk("sr_busy", int'(busy), 0);
        chk("sr_enable", int'(enable), 0);
        chk("sr_color", int'(color), 1);
        chk("sr_ready", int'(req_ready), 0);
        tick();
        chk("sr_no_xfer_busy", int'(busy), 0);
        chk("sr_no_xfer_color", int'(color), 1);
        chk("sr_ready_back", int'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        chk("sr_xfer_busy", int'(busy), 1);
        chk("sr_xfer_color", int'(color), 3);
        chk("sr_xfer_ready", int'(req_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
